sccb_slave: RTL and testbench

- SCCB/I2C-style slave responder; the far end of the camera-control serial bus.
- Decodes 3-phase write and 2-phase read transactions on sio_c/sio_d against a 256x8 register file.
- Used as the camera-side register model in simulation and as an on-fabric sniffer/target.
- Sits between the tri-state pad (top level drives sio_d low when sio_d_oe_o=1, else Z) and fabric logic that consumes register writes.

---
 rtl/sccb_slave.sv | 176 +++++++++++++++++
 tb/tb_sccb_slave.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_slave.sv
// SCCB/I2C-style slave responder backed by a 256x8 register file.
// Decodes 3-phase writes (id, sub-address, data...) and, when the
// SCCB_SLAVE_RD_EN macro is defined, 2-phase reads (id, data...).
// Without SCCB_SLAVE_RD_EN a read id is not acknowledged and sio_d_oe_o
// is only ever asserted during ACK slots.
module sccb_slave #(
   parameter logic [6:0] DEV_ID      = 7'h21,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       sys_clk_i,
   input  logic       sys_rst_i,
   input  logic       sio_c_i,
   input  logic       sio_d_i,
   output logic       sio_d_oe_o,
   output logic       wr_en_o,
   output logic [7:0] wr_addr_o,
   output logic [7:0] wr_data_o,
   output logic       busy_o,
   input  logic [7:0] rd_addr_i,
   output logic [7:0] rd_data_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_DEV_ID, S_SUB_ADDR, S_WR_DATA, S_ACK, S_RD_DATA, S_WAIT_STOP
   } state_t;

   logic [SYNC_STAGES-1:0] c_sync, d_sync;
   logic                   c_q, d_q;
   logic                   scl, sda;
   logic                   scl_rise, scl_fall, start, stop;

   state_t     state, nxt;
   logic [7:0] sh;
   logic [3:0] cnt;
   logic [7:0] ptr;
   logic [7:0] mem [256];
   logic       wr_fire;
   logic [7:0] wr_byte;

   // Synchronizers plus one edge-detect stage; idle bus level is high.
   always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
      if (!sys_rst_i) begin
         c_sync <= '1;
         d_sync <= '1;
         c_q    <= 1'b1;
         d_q    <= 1'b1;
      end else begin
         c_sync <= {c_sync[SYNC_STAGES-2:0], sio_c_i};
         d_sync <= {d_sync[SYNC_STAGES-2:0], sio_d_i};
         c_q    <= c_sync[SYNC_STAGES-1];
         d_q    <= d_sync[SYNC_STAGES-1];
      end
   end

   assign scl      = c_sync[SYNC_STAGES-1];
   assign sda      = d_sync[SYNC_STAGES-1];
   assign scl_rise = scl & ~c_q;
   assign scl_fall = ~scl & c_q;
   // SDA edges count as START/STOP only while SCL is steadily high.
   assign start    = scl & c_q & ~sda & d_q;
   assign stop     = scl & c_q & sda & ~d_q;

   assign wr_byte  = {sh[6:0], sda};
   assign wr_fire  = (state == S_WR_DATA) && scl_rise && (cnt == 4'd7) && !start && !stop;

   // Register file write port; contents are deliberately not reset.
   always_ff @(posedge sys_clk_i) begin
      if (wr_fire) mem[ptr] <= wr_byte;
   end

   // Fabric read port, one cycle latency.
   always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
      if (!sys_rst_i) rd_data_o <= 8'h00;
      else            rd_data_o <= mem[rd_addr_i];
   end

   // Bus protocol FSM; START/STOP override any bit-level activity.
   always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
      if (!sys_rst_i) begin
         state      <= S_IDLE;
         nxt        <= S_IDLE;
         sh         <= 8'h00;
         cnt        <= 4'd0;
         ptr        <= 8'h00;
         sio_d_oe_o <= 1'b0;
         busy_o     <= 1'b0;
         wr_en_o    <= 1'b0;
         wr_addr_o  <= 8'h00;
         wr_data_o  <= 8'h00;
      end else begin
         wr_en_o <= 1'b0;
         if (start) begin
            state      <= S_DEV_ID;
            cnt        <= 4'd0;
            busy_o     <= 1'b1;
            sio_d_oe_o <= 1'b0;
         end else if (stop) begin
            state      <= S_IDLE;
            busy_o     <= 1'b0;
            sio_d_oe_o <= 1'b0;
         end else begin
            case (state)
               S_DEV_ID, S_SUB_ADDR, S_WR_DATA: begin
                  if (scl_rise && cnt < 4'd8) begin
                     sh  <= wr_byte;
                     cnt <= cnt + 4'd1;
                     if (state == S_SUB_ADDR && cnt == 4'd7) ptr <= wr_byte;
                     if (wr_fire) begin
                        wr_en_o   <= 1'b1;
                        wr_addr_o <= ptr;
                        wr_data_o <= wr_byte;
                        ptr       <= ptr + 8'd1;
                     end
                  end else if (scl_fall && cnt == 4'd8) begin
                     if (state != S_DEV_ID) begin
                        sio_d_oe_o <= 1'b1;
                        state      <= S_ACK;
                        nxt        <= S_WR_DATA;
                     end else if (sh[7:1] != DEV_ID) begin
                        state <= S_WAIT_STOP;
                     end else if (!sh[0]) begin
                        sio_d_oe_o <= 1'b1;
                        state      <= S_ACK;
                        nxt        <= S_SUB_ADDR;
                     end else begin
`ifdef SCCB_SLAVE_RD_EN
                        sio_d_oe_o <= 1'b1;
                        state      <= S_ACK;
                        nxt        <= S_RD_DATA;
`else
                        state <= S_WAIT_STOP;
`endif
                     end
                  end
               end
               S_ACK: begin
                  if (scl_fall) begin
                     sio_d_oe_o <= 1'b0;
                     cnt        <= 4'd0;
                     state      <= nxt;
`ifdef SCCB_SLAVE_RD_EN
                     // Read data MSB goes out on the same fall that ends the ACK.
                     if (nxt == S_RD_DATA) begin
                        sio_d_oe_o <= ~mem[ptr][7];
                        sh         <= {mem[ptr][6:0], 1'b0};
                     end
`endif
                  end
               end
`ifdef SCCB_SLAVE_RD_EN
               S_RD_DATA: begin
                  if (scl_rise) begin
                     if (cnt < 4'd8)  cnt <= cnt + 4'd1;
                     else if (!sda) begin
                        ptr <= ptr + 8'd1;
                        cnt <= 4'd0;
                     end else state <= S_WAIT_STOP;
                  end else if (scl_fall) begin
                     // cnt==0 here means the master acked: start the next byte.
                     if (cnt == 4'd0) begin
                        sio_d_oe_o <= ~mem[ptr][7];
                        sh         <= {mem[ptr][6:0], 1'b0};
                     end else if (cnt < 4'd8) begin
                        sio_d_oe_o <= ~sh[7];
                        sh         <= {sh[6:0], 1'b0};
                     end else sio_d_oe_o <= 1'b0;
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sccb_slave.sv
// Self-checking bench for sccb_slave: directed protocol cases plus a
// randomized mix of burst writes, bad ids and reads, checked against an
// array model of the register file and the expected write-strobe stream.
module tb_sccb_slave;
   localparam int Q = 100;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl = 1'b1;
   logic       sda_m = 1'b1;
   logic [7:0] rd_addr = 8'h00;
   logic       oe, wr_en, busy;
   logic [7:0] wr_addr, wr_data, rd_data;
   logic       sda_bus;

   assign sda_bus = sda_m & ~oe;

   always #5 clk = ~clk;

   sccb_slave dut (
      .sys_clk_i (clk),     .sys_rst_i (rst_n),
      .sio_c_i   (scl),     .sio_d_i   (sda_bus),
      .sio_d_oe_o(oe),      .wr_en_o   (wr_en),
      .wr_addr_o (wr_addr), .wr_data_o (wr_data),
      .busy_o    (busy),    .rd_addr_i (rd_addr),
      .rd_data_o (rd_data)
   );

   int nvec = 0;
   int nerr = 0;
   logic [15:0] wq[$];
   int oe_cnt = 0;
   logic [7:0] mem_m [256];
   bit         known [256];
   logic [7:0] dq[$];

   // Capture every write strobe and count cycles with the pad pulled low.
   always @(negedge clk) begin
      if (wr_en) wq.push_back({wr_addr, wr_data});
      if (oe) oe_cnt <= oe_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic m_start();
      sda_m = 1'b1; #Q; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
   endtask

   task automatic m_stop();
      sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #Q;
   endtask

   task automatic bit_tx(input logic b, output logic smp);
      sda_m = b; #Q; scl = 1'b1; #Q; smp = sda_bus; #Q; scl = 1'b0; #Q;
   endtask

   task automatic wbyte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_tx(b[i], s);
      bit_tx(1'b1, s);
      ack = ~s;
   endtask

   task automatic rbyte(input logic nack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_tx(1'b1, s);
         d[i] = s;
      end
      bit_tx(nack, s);
   endtask

   task automatic fab_chk(input logic [7:0] a);
      @(negedge clk) rd_addr = a;
      @(posedge clk); #1;
      chk("rd_data", {24'h0, rd_data}, {24'h0, mem_m[a]});
   endtask

   // Expects wq cleared by the caller; checks strobes and updates the model.
   task automatic do_write(input logic [7:0] a, input logic [7:0] d[$]);
      logic ack;
      logic [7:0] aa;
      m_start();
      chk("busy_start", {31'h0, busy}, 32'h1);
      wbyte(8'h42, ack); chk("ack_id", {31'h0, ack}, 32'h1);
      wbyte(a, ack);     chk("ack_sub", {31'h0, ack}, 32'h1);
      foreach (d[i]) begin
         wbyte(d[i], ack); chk("ack_data", {31'h0, ack}, 32'h1);
      end
      m_stop();
      #(4*Q);
      chk("busy_stop", {31'h0, busy}, 32'h0);
      chk("wr_count", wq.size(), d.size());
      foreach (d[i]) begin
         aa = a + 8'(i);
         if (i < wq.size()) chk("wr_pulse", {16'h0, wq[i]}, {16'h0, aa, d[i]});
         mem_m[aa] = d[i];
         known[aa] = 1'b1;
      end
      foreach (d[i]) fab_chk(a + 8'(i));
   endtask

   task automatic do_read(input logic [7:0] a, input int n);
      logic ack;
      logic [7:0] d, aa;
      m_start(); wbyte(8'h42, ack); wbyte(a, ack); m_stop();
      m_start();
      wbyte(8'h43, ack);
`ifdef SCCB_SLAVE_RD_EN
      chk("ack_rd_id", {31'h0, ack}, 32'h1);
      for (int i = 0; i < n; i++) begin
         rbyte(i == n - 1, d);
         aa = a + 8'(i);
         if (known[aa]) chk("rd_bus", {24'h0, d}, {24'h0, mem_m[aa]});
      end
`else
      chk("nak_rd_id", {31'h0, ack}, 32'h0);
`endif
      m_stop();
      #(4*Q);
      chk("busy_rd_stop", {31'h0, busy}, 32'h0);
   endtask

   task automatic bad_id(input logic [7:0] id);
      logic ack;
      int base;
      wq.delete();
      base = oe_cnt;
      m_start();
      wbyte(id, ack);
      chk("nak_bad_id", {31'h0, ack}, 32'h0);
      chk("no_oe_bad_id", oe_cnt - base, 0);
      chk("busy_wait", {31'h0, busy}, 32'h1);
      m_stop();
      #(4*Q);
      chk("busy_bad_stop", {31'h0, busy}, 32'h0);
      chk("no_wr_bad_id", wq.size(), 0);
   endtask

   initial begin
      logic s;
      logic ack;
      logic [7:0] last_a;
      int last_n;
      last_a = 8'h00;
      last_n = 0;

      // Reset state
      #23;
      chk("rst_oe", {31'h0, oe}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_wr_en", {31'h0, wr_en}, 32'h0);
      chk("rst_wr_addr", {24'h0, wr_addr}, 32'h0);
      chk("rst_wr_data", {24'h0, wr_data}, 32'h0);
      chk("rst_rd_data", {24'h0, rd_data}, 32'h0);
      rst_n = 1'b1;
      #(4*Q);

      // 1: simple write
      wq.delete(); dq.delete(); dq.push_back(8'h80);
      do_write(8'h12, dq);

      // 2: wrong device id
      bad_id(8'h60);

      // 3: write, set pointer, read back
      wq.delete(); dq.delete(); dq.push_back(8'h76);
      do_write(8'h0A, dq);
      do_read(8'h0A, 1);

      // 4: burst wrapping the pointer
      wq.delete(); dq.delete(); dq.push_back(8'h11); dq.push_back(8'h22);
      do_write(8'hFF, dq);

      // 5: repeated START inside a data byte drops the partial byte
      wq.delete();
      m_start(); wbyte(8'h42, ack); wbyte(8'h30, ack);
      for (int i = 0; i < 4; i++) bit_tx(i[0], s);
      dq.delete(); dq.push_back(8'h55);
      do_write(8'h30, dq);

      // 6: reset during an ACK slot
      wq.delete();
      m_start();
      for (int i = 7; i >= 0; i--) bit_tx(i == 6 || i == 1, s);
      sda_m = 1'b1; #Q;
      chk("oe_in_ack", {31'h0, oe}, 32'h1);
      rst_n = 1'b0; #1;
      chk("oe_async_rst", {31'h0, oe}, 32'h0);
      chk("busy_async_rst", {31'h0, busy}, 32'h0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      chk("wr_addr_after_rst", {24'h0, wr_addr}, 32'h0);
      scl = 1'b1; #Q; scl = 1'b0; #Q;
      m_stop();
      wq.delete(); dq.delete(); dq.push_back(8'h3E);
      do_write(8'h5C, dq);

      // Randomized mix
      for (int it = 0; it < 12; it++) begin
         int kind;
         kind = $urandom_range(0, 3);
         if (kind == 3 && last_n > 0) begin
            do_read(last_a, $urandom_range(1, last_n));
         end else if (kind == 2) begin
            logic [7:0] id;
            id = 8'($urandom_range(0, 255));
            if (id[7:1] == 7'h21) id = id ^ 8'h80;
            bad_id(id);
         end else begin
            logic [7:0] a;
            int n;
            a = 8'($urandom_range(0, 255));
            n = $urandom_range(1, 4);
            dq.delete();
            for (int k = 0; k < n; k++) dq.push_back(8'($urandom_range(0, 255)));
            wq.delete();
            do_write(a, dq);
            last_a = a;
            last_n = n;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
